lvds_transmit: RTL and testbench
================================

# lvds_transmit

Source-synchronous LVDS transmitter and counterpart of the `LVDS_capture` receiver. It accepts 16-bit words over a valid/ready handshake and buffers them in a small FIFO. It serializes each word as two 8-bit halves onto 8 differential data lanes, one half per edge of a forwarded differential clock. A training pattern is sent after reset and on request so the receiver can align; idle words fill any gap in the data stream.

## Interface
Parameters:
- `LANES`, 8: differential data lanes; word width is 2*LANES.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, minimum 2.
- `TRAIN_WORDS`, 16: words sent per training burst, minimum 1.

Ports:
- `clk` input 1: single clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `tx_data` input 16: word to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: FIFO can accept a word.
- `train_req` input 1: single-cycle pulse that requests a training burst.
- `training` output 1: high while training words are being driven.
- `idle_cnt` output 16: saturating count of idle words inserted while in SEND.
- `capture_data_p` output 8: data lanes, true polarity.
- `capture_data_n` output 8: always the bitwise complement of `capture_data_p`.
- `clk_out_p` output 1: forwarded clock, true polarity.
- `clk_out_n` output 1: always `~clk_out_p`.

## Operation
- All outputs are registered.
- Reset values:
  - `clk_out_p`=0, `clk_out_n`=1.
  - `capture_data_p`=8'h00, `capture_data_n`=8'hFF.
  - `tx_ready`=0, `training`=1, `idle_cnt`=0.
  - FIFO empty, state TRAIN, training counter 0.
- Forwarded clock: `clk_out_p` toggles on every `clk` edge after reset is released, giving a period of 2 `clk` cycles.
- Word boundary: the edge at which `clk_out_p` goes 0→1.
  - At this edge the next word is selected and its low byte `[7:0]` is driven.
  - At the following edge (1→0) its high byte `[15:8]` is driven.
- Word selection at each boundary:
  - TRAIN: `TRAIN_WORD` (16'h5AA5).
  - SEND with FIFO non-empty: the FIFO head, popped at this edge.
  - SEND with FIFO empty: `IDLE_WORD` (16'h0000). `idle_cnt` increments and saturates at 16'hFFFF.
- State machine:
  - TRAIN→SEND after `TRAIN_WORDS` training words have been selected. The first SEND word is selected at the next boundary.
  - SEND→TRAIN at the first boundary after a latched `train_req`.
- `train_req` handling:
  - The request is latched until a boundary consumes it.
  - A `train_req` received during TRAIN restarts the training counter at the next boundary.
- `training` is registered and equals (state == TRAIN) for the word currently on the lanes. It changes only at boundaries.
- FIFO push and pop:
  - A push happens when `tx_valid && tx_ready`.
  - `tx_ready` = !full, and is 0 during reset.
  - Pushes are accepted in both states. The FIFO is never popped in TRAIN.
  - A simultaneous push and pop when full is impossible because `tx_ready`=0.
  - A simultaneous push and pop when empty is allowed. The pop sees the pre-push state, so an idle word is sent and the pushed word is kept.
- Reset asserted mid-word aborts the word in progress. All FIFO contents are discarded and all outputs return to their reset values on the next edge.

## Timing
- A word accepted at edge E into an empty FIFO, in SEND:
  - its low byte is on the lanes after edge E+1 if `clk_out_p` was 0 at E+1, otherwise after edge E+2;
  - its high byte follows one cycle later.
- Back-to-back throughput is one word per 2 cycles. Sustained `tx_valid` with the FIFO full stalls via `tx_ready` with no word loss.
- First edge after reset release: `clk_out_p`=1, lanes = 8'hA5 (`training`=1). Next edge: `clk_out_p`=0, lanes = 8'h5A.
- `TRAIN_WORDS`=16: the first SEND word's low byte appears at the 33rd edge after reset release.
- Data and clock change on the same `clk` edge. Centring the capture window is the receiver's job (I/O delay) and outside this block.

## Structure
- Package `lvds_pkg`: `LANES`, `TRAIN_WORD`, `IDLE_WORD`, and state enum `lvds_tx_state_t` {TRAIN, SEND}. `LVDS_capture` also uses this package.
- Sub-module `lvds_tx_fifo`: synchronous FIFO, parameterized width and depth, with `full`/`empty` flags and a first-word-fall-through head.
- The top level holds the phase toggle, the state machine, the training counter, the byte mux and `idle_cnt`.

## Test plan
- Reset, then 40 cycles with no input → the first 16 words are A5/5A byte pairs with `training`=1. The following words are 00/00, and `idle_cnt` counts 1,2,3…
- After training, push 16'h0201 and then 16'h0403 back-to-back → lanes show 01,02,03,04 on consecutive edges. `clk_out_n`==~`clk_out_p` and `capture_data_n`==~`capture_data_p` on every cycle.
- `tx_valid` held high for 20 cycles with incrementing data → `tx_ready` drops when the FIFO holds 4 words. The output sequence is exactly the accepted words in order, with none dropped and none duplicated.
- `train_req` pulsed mid-word in SEND, with words queued → the current word completes, then 16 A5/5A words are sent. The queued words resume afterwards in order.
- `rst` asserted on a high-byte cycle with 3 words queued → on the next edge all outputs take their reset values and `tx_ready`=0. After release, a fresh training burst is sent and no old data appears.
- `idle_cnt` preloaded near its limit by forcing, then idle words sent → the count reaches 16'hFFFF and holds there.

Source files
------------

// File: rtl/lvds_pkg.sv
// Constants and state type shared by the LVDS transmitter and the LVDS_capture receiver.
package lvds_pkg;

    localparam int LANES  = 8;
    localparam int WORD_W = 2 * LANES;

    localparam logic [WORD_W-1:0] TRAIN_WORD = 16'h5AA5;
    localparam logic [WORD_W-1:0] IDLE_WORD  = 16'h0000;

    typedef enum logic {
        TRAIN = 1'b0,
        SEND  = 1'b1
    } lvds_tx_state_t;

endpackage

// File: rtl/lvds_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through head; reset clears pointers and count only.
module lvds_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_full_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_full_nxt  = (w_count_nxt == CW'(DEPTH));
    assign o_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/lvds_transmit.sv
// Source-synchronous LVDS transmitter: FIFO-buffered words sent low byte then high byte
// per forwarded-clock period, with training bursts and idle fill.
module lvds_transmit #(
    parameter int LANES       = lvds_pkg::LANES,
    parameter int FIFO_DEPTH  = 4,
    parameter int TRAIN_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*LANES-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic               train_req,
    output logic               training,
    output logic [15:0]        idle_cnt,
    output logic [LANES-1:0]   capture_data_p,
    output logic [LANES-1:0]   capture_data_n,
    output logic               clk_out_p,
    output logic               clk_out_n
);
    import lvds_pkg::*;

    localparam int W     = 2 * LANES;
    localparam int CNT_W = $clog2(TRAIN_WORDS + 1);
    localparam logic [W-1:0]     TRAIN_W  = W'(TRAIN_WORD);
    localparam logic [W-1:0]     IDLE_W   = W'(IDLE_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_WORDS);

    lvds_tx_state_t   r_state, w_state_nxt;
    logic [CNT_W-1:0] r_train_cnt, w_cnt_nxt, w_cnt_base, w_cnt_inc;
    logic             r_clk_p, r_clk_n;
    logic [LANES-1:0] r_lanes_p, r_lanes_n, r_hi;
    logic             r_training, r_req, r_tx_ready;
    logic [15:0]      r_idle_cnt;
    logic             w_boundary, w_req, w_push, w_pop, w_sel_train, w_idle_inc;
    logic [W-1:0]     w_word, w_head;
    logic             w_full, w_empty, w_full_nxt;

    assign w_boundary = !r_clk_p;
    assign w_req      = r_req || train_req;
    assign w_push     = tx_valid && r_tx_ready;

    lvds_tx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_din      (tx_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_full_nxt (w_full_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= TRAIN;
            r_train_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_train_cnt <= w_cnt_nxt;
        end
    end

    // A pending request restarts the burst count; the word it selects is the first of the burst.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_train_cnt;
        w_cnt_base  = '0;
        w_cnt_inc   = '0;
        w_word      = IDLE_W;
        w_sel_train = 1'b0;
        w_pop       = 1'b0;
        w_idle_inc  = 1'b0;
        if (w_boundary) begin
            if (r_state == TRAIN || w_req) begin
                w_word      = TRAIN_W;
                w_sel_train = 1'b1;
                w_cnt_base  = w_req ? '0 : r_train_cnt;
                w_cnt_inc   = w_cnt_base + CNT_W'(1);
                if (w_cnt_inc == CNT_LAST) begin
                    w_state_nxt = SEND;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = TRAIN;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end else if (!w_empty) begin
                w_word = w_head;
                w_pop  = 1'b1;
            end else begin
                w_idle_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_p    <= 1'b0;
            r_clk_n    <= 1'b1;
            r_lanes_p  <= '0;
            r_lanes_n  <= '1;
            r_training <= 1'b1;
            r_req      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            r_clk_p    <= ~r_clk_p;
            r_clk_n    <= r_clk_p;
            r_req      <= w_boundary ? 1'b0 : w_req;
            r_tx_ready <= !w_full_nxt;
            if (w_boundary) begin
                r_lanes_p  <= w_word[LANES-1:0];
                r_lanes_n  <= ~w_word[LANES-1:0];
                r_training <= w_sel_train;
            end else begin
                r_lanes_p <= r_hi;
                r_lanes_n <= ~r_hi;
            end
            if (w_idle_inc && r_idle_cnt != 16'hFFFF) r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_boundary) r_hi <= w_word[W-1:LANES];
    end

    assign tx_ready       = r_tx_ready;
    assign training       = r_training;
    assign idle_cnt       = r_idle_cnt;
    assign capture_data_p = r_lanes_p;
    assign capture_data_n = r_lanes_n;
    assign clk_out_p      = r_clk_p;
    assign clk_out_n      = r_clk_n;

endmodule

// File: tb/tb_lvds_transmit.sv
// Directed bench for lvds_transmit: vector table for start-up and back-to-back words,
// plus sequences for stall, training request, mid-word reset and idle saturation.
module tb_lvds_transmit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        train_req = 1'b0;
    logic        training;
    logic [15:0] idle_cnt;
    logic [7:0]  dp, dn;
    logic        cp, cn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        e_cp;
        logic [7:0]  e_lanes;
        logic        e_trn;
        logic [15:0] e_idle;
    } vec_t;

    vec_t        tab [47];
    logic [15:0] exp_q [$];
    int          acc, started, tcount;
    logic        mon_en, comp_en, pend_t, pend_d, saw_stall;
    logic [7:0]  lo;

    always #5 clk = ~clk;

    lvds_transmit #(
        .LANES       (8),
        .FIFO_DEPTH  (4),
        .TRAIN_WORDS (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .train_req      (train_req),
        .training       (training),
        .idle_cnt       (idle_cnt),
        .capture_data_p (dp),
        .capture_data_n (dn),
        .clk_out_p      (cp),
        .clk_out_n      (cn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (comp_en) begin
            total++;
            if (cn !== ~cp) begin
                bad++;
                $display("FAIL clk_n: clk_out_p=%b clk_out_n=%b", cp, cn);
            end
            total++;
            if (dn !== ~dp) begin
                bad++;
                $display("FAIL data_n: data_p=%h data_n=%h", dp, dn);
            end
        end
    end

    task automatic monitor();
        logic [15:0] w;
        if (cp && training) begin
            tcount++;
            chk("train_lo", 32'(dp), 32'h A5);
            pend_t = 1'b1;
            pend_d = 1'b0;
        end else if (cp) begin
            lo     = dp;
            pend_d = 1'b1;
            pend_t = 1'b0;
            if (dp != 8'h00) started++;
        end else begin
            if (pend_t) begin
                chk("train_hi", 32'(dp), 32'h5A);
            end else if (pend_d) begin
                w = {dp, lo};
                if (w != 16'h0000) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word: got %h expected no data word", w);
                    end else begin
                        chk("word", 32'(w), 32'(exp_q.pop_front()));
                    end
                end
            end
            pend_t = 1'b0;
            pend_d = 1'b0;
        end
        if (!rst) chk("tx_ready", 32'(tx_ready), 32'((acc - started) != 4));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_en) monitor();
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        tx_valid = v;
        tx_data  = d;
        if (v && !tx_ready) saw_stall = 1'b1;
        if (v && tx_ready) begin
            exp_q.push_back(d);
            acc++;
        end
    endtask

    task automatic align_low();
        for (int n = 0; n < 4 && !cp; n++) step();
        chk("align", 32'(cp), 32'd1);
    endtask

    task automatic chk_reset();
        chk("rst_clk_p", 32'(cp), 32'd0);
        chk("rst_clk_n", 32'(cn), 32'd1);
        chk("rst_dp", 32'(dp), 32'h00);
        chk("rst_dn", 32'(dn), 32'hFF);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        chk("rst_training", 32'(training), 32'd1);
        chk("rst_idle", 32'(idle_cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc = 0; started = 0; tcount = 0;
        mon_en = 1'b0; comp_en = 1'b0; pend_t = 1'b0; pend_d = 1'b0; saw_stall = 1'b0;
        lo = '0;

        // Start-up: 16 training words then idle words; edge k counts from reset release.
        for (int k = 1; k <= 40; k++) begin
            tab[k-1].v       = 1'b0;
            tab[k-1].d       = 16'h0000;
            tab[k-1].e_cp    = (k % 2 == 1);
            tab[k-1].e_lanes = (k <= 32) ? ((k % 2 == 1) ? 8'hA5 : 8'h5A) : 8'h00;
            tab[k-1].e_trn   = (k <= 32);
            tab[k-1].e_idle  = (k >= 33) ? 16'((k - 31) / 2) : 16'd0;
        end
        // Push into an empty FIFO on a boundary: idle goes out, word is kept.
        tab[40] = '{1'b1, 16'h0201, 1'b1, 8'h00, 1'b0, 16'd5};
        tab[41] = '{1'b1, 16'h0403, 1'b0, 8'h00, 1'b0, 16'd5};
        tab[42] = '{1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 16'd5};
        tab[43] = '{1'b0, 16'h0000, 1'b0, 8'h02, 1'b0, 16'd5};
        tab[44] = '{1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 16'd5};
        tab[45] = '{1'b0, 16'h0000, 1'b0, 8'h04, 1'b0, 16'd5};
        tab[46] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 16'd6};

        step();
        comp_en = 1'b1;
        step();
        chk_reset();
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 47; i++) begin
            drive(tab[i].v, tab[i].d);
            step();
            chk($sformatf("clk_p[%0d]", i), 32'(cp), 32'(tab[i].e_cp));
            chk($sformatf("lanes[%0d]", i), 32'(dp), 32'(tab[i].e_lanes));
            chk($sformatf("training[%0d]", i), 32'(training), 32'(tab[i].e_trn));
            chk($sformatf("idle_cnt[%0d]", i), 32'(idle_cnt), 32'(tab[i].e_idle));
        end
        chk("q_empty_b2b", 32'(exp_q.size()), 32'd0);

        // Sustained valid: FIFO fills, tx_ready stalls, nothing lost or duplicated.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'hA101 + 16'(i));
            step();
        end
        drive(1'b0, 16'h0000);
        for (int i = 0; i < 30; i++) step();
        chk("stall_seen", 32'(saw_stall), 32'd1);
        chk("q_empty_stall", 32'(exp_q.size()), 32'd0);

        // Training request mid-word with words queued.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hC101 + 16'(i));
            step();
        end
        drive(1'b0, 16'h0000);
        align_low();
        tcount    = 0;
        train_req = 1'b1;
        step();
        train_req = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("train_burst_len", 32'(tcount), 32'd16);
        chk("q_empty_train", 32'(exp_q.size()), 32'd0);
        chk("training_done", 32'(training), 32'd0);

        // Reset on a high-byte cycle with 3 words queued during training.
        train_req = 1'b1;
        step();
        train_req = 1'b0;
        for (int n = 0; n < 4 && !training; n++) step();
        chk("train_entered", 32'(training), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hD101 + 16'(i));
            step();
        end
        drive(1'b0, 16'h0000);
        chk("queued_before_rst", 32'(exp_q.size()), 32'd3);
        align_low();
        rst    = 1'b1;
        mon_en = 1'b0;
        step();
        chk_reset();
        rst = 1'b0;
        exp_q.delete();
        acc = 0; started = 0; tcount = 0;
        pend_t = 1'b0; pend_d = 1'b0;
        mon_en = 1'b1;
        step();
        chk("post_rst_clk_p", 32'(cp), 32'd1);
        chk("post_rst_lanes", 32'(dp), 32'hA5);
        chk("post_rst_training", 32'(training), 32'd1);
        for (int i = 0; i < 39; i++) step();
        chk("post_rst_burst", 32'(tcount), 32'd16);
        chk("post_rst_idle", 32'(idle_cnt), 32'd4);

        // idle_cnt saturation from a preloaded value.
        align_low();
        force dut.r_idle_cnt = 16'hFFFD;
        step();
        release dut.r_idle_cnt;
        chk("idle_preload", 32'(idle_cnt), 32'hFFFD);
        step();
        chk("idle_fffe", 32'(idle_cnt), 32'hFFFE);
        step();
        step();
        chk("idle_ffff", 32'(idle_cnt), 32'hFFFF);
        step();
        step();
        chk("idle_sat1", 32'(idle_cnt), 32'hFFFF);
        step();
        step();
        chk("idle_sat2", 32'(idle_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
